// File: rtl/iqmap_pkg.sv
// iqmap_pkg: shared types and helpers for the multi-mode I/Q symbol mapper.
//   mode_e        - modulation selector carried with every accepted word
//   GRAY_*        - 16QAM per-axis Gray codes, written {first bit, second bit}
//   bits_per_mode - bits consumed per symbol for a given mode
package iqmap_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_16QAM = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  // First bit selects sign, second bit selects the inner (A) or outer (3A) level.
  localparam logic [1:0] GRAY_P3 = 2'b00;
  localparam logic [1:0] GRAY_P1 = 2'b01;
  localparam logic [1:0] GRAY_M1 = 2'b11;
  localparam logic [1:0] GRAY_M3 = 2'b10;

  // Reserved mode falls through to BPSK.
  function automatic logic [2:0] bits_per_mode(input mode_e m);
    case (m)
      MODE_QPSK:  return 3'd2;
      MODE_16QAM: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/iqmap_symbol_lut.sv
// iqmap_symbol_lut: combinational (mode, symbol bits) -> signed I/Q mapping.
//   mode - modulation of the symbol being mapped
//   bits - symbol bits, bit0 = first bit consumed; bits beyond the mode's width ignored
//   xr   - signed in-phase value, OUT_W bits
//   xi   - signed quadrature value, OUT_W bits
module iqmap_symbol_lut
  import iqmap_pkg::*;
#(
  parameter int unsigned OUT_W = 11,
  parameter int unsigned AMP   = 256
) (
  input  mode_e                   mode,
  input  logic [3:0]              bits,
  output logic signed [OUT_W-1:0] xr,
  output logic signed [OUT_W-1:0] xi
);

  localparam logic signed [OUT_W-1:0] LVL1 = OUT_W'(AMP);
  localparam logic signed [OUT_W-1:0] LVL3 = OUT_W'(3 * AMP);

  function automatic logic signed [OUT_W-1:0] bpsk_level(input logic b);
    return b ? -LVL1 : LVL1;
  endfunction

  function automatic logic signed [OUT_W-1:0] qam_level(input logic [1:0] g);
    case (g)
      GRAY_P3: return LVL3;
      GRAY_P1: return LVL1;
      GRAY_M1: return -LVL1;
      default: return -LVL3;
    endcase
  endfunction

  always_comb begin
    xr = bpsk_level(bits[0]);
    xi = '0;
    case (mode)
      MODE_QPSK: begin
        xr = bpsk_level(bits[0]);
        xi = bpsk_level(bits[1]);
      end
      MODE_16QAM: begin
        // I axis uses bits 0/2, Q axis bits 1/3.
        xr = qam_level({bits[0], bits[2]});
        xi = qam_level({bits[1], bits[3]});
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/iqmap_multi.sv
// iqmap_multi: serialises packed payload words LSB-first into BPSK/QPSK/16QAM
// Gray-coded I/Q symbols, with a one-word pending buffer for gap-free output.
//   CLK, RST         - clock (rising edge), asynchronous active-low reset
//   ce               - downstream advance enable; outputs hold while low
//   mode             - 0 BPSK, 1 QPSK, 2 16QAM, 3 reserved (BPSK); taken with each word
//   in_valid/in_data - payload word offer
//   in_ready         - a word can be accepted this cycle (pending slot empty)
//   xr, xi           - registered signed I/Q symbol
//   valid_o          - xr/xi/raw/last hold a valid symbol
//   raw              - symbol bits, bit0 first, unused bits zero
//   last             - symbol is the final one of its word
module iqmap_multi
  import iqmap_pkg::*;
#(
  parameter int unsigned WORD_W = 128,
  parameter int unsigned OUT_W  = 11,
  parameter int unsigned AMP    = 256
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ce,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_data,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] xr,
  output logic signed [OUT_W-1:0] xi,
  output logic                    valid_o,
  output logic [3:0]              raw,
  output logic                    last
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  if (3 * AMP > (2 ** (OUT_W - 1)) - 1) begin : g_amp_check
    $error("iqmap_multi: 3*AMP does not fit in signed OUT_W");
  end
  if (WORD_W % 4 != 0) begin : g_word_check
    $error("iqmap_multi: WORD_W must be a multiple of 4");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q;
  logic [WORD_W-1:0]   act_word_q, pend_word_q;
  mode_e               act_mode_q, pend_mode_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pend_full_q;

  mode_e               in_mode;
  logic [2:0]          k;
  logic [CNT_W-1:0]    k_step, last_idx;
  logic [3:0]          sym_bits, raw_bits;
  logic                accept, issue, word_done;
  logic signed [OUT_W-1:0] map_xr, map_xi;

  assign in_mode  = mode_e'(mode);
  assign in_ready = !pend_full_q;
  assign accept   = in_valid && !pend_full_q;

  always_comb begin
    k         = bits_per_mode(act_mode_q);
    k_step    = CNT_W'(k);
    last_idx  = CNT_W'(WORD_W - 32'(k));
    sym_bits  = 4'(act_word_q >> cnt_q);
    // (1 << k) - 1 wraps to 4'hF for k = 4.
    raw_bits  = sym_bits & ((4'd1 << k) - 4'd1);
    issue     = (state_q == StRun) && ce;
    word_done = issue && (cnt_q == last_idx);
  end

  iqmap_symbol_lut #(
    .OUT_W (OUT_W),
    .AMP   (AMP)
  ) u_lut (
    .mode (act_mode_q),
    .bits (sym_bits),
    .xr   (map_xr),
    .xi   (map_xi)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      act_word_q  <= '0;
      act_mode_q  <= MODE_BPSK;
      pend_word_q <= '0;
      pend_mode_q <= MODE_BPSK;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
      xr          <= '0;
      xi          <= '0;
      raw         <= '0;
      last        <= 1'b0;
      valid_o     <= 1'b0;
    end else begin
      if (issue) begin
        xr      <= map_xr;
        xi      <= map_xi;
        raw     <= raw_bits;
        last    <= word_done;
        valid_o <= 1'b1;
      end else if (ce && state_q == StIdle) begin
        valid_o <= 1'b0;
      end

      if (state_q == StIdle) begin
        if (accept) begin
          act_word_q <= in_data;
          act_mode_q <= in_mode;
          cnt_q      <= '0;
          state_q    <= StRun;
        end
      end else if (word_done) begin
        cnt_q <= '0;
        if (pend_full_q) begin
          act_word_q  <= pend_word_q;
          act_mode_q  <= pend_mode_q;
          pend_full_q <= 1'b0;
        end else if (accept) begin
          // Pending empty: the new word goes straight to active, no bubble.
          act_word_q <= in_data;
          act_mode_q <= in_mode;
        end else begin
          state_q <= StIdle;
        end
      end else begin
        if (issue) begin
          cnt_q <= cnt_q + k_step;
        end
        if (accept) begin
          pend_word_q <= in_data;
          pend_mode_q <= in_mode;
          pend_full_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iqmap_multi.sv
module tb_iqmap_multi;

  logic               CLK = 1'b0;
  logic               RST;
  logic               ce;
  logic [1:0]         mode;
  logic               in_valid;
  logic [127:0]       in_data;
  logic               in_ready;
  logic signed [10:0] xr, xi;
  logic               valid_o;
  logic [3:0]         raw;
  logic               last;

  iqmap_multi #(
    .WORD_W (128),
    .OUT_W  (11),
    .AMP    (256)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ce       (ce),
    .mode     (mode),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .xr       (xr),
    .xi       (xi),
    .valid_o  (valid_o),
    .raw      (raw),
    .last     (last)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int xr;
    int xi;
    int raw;
    int last;
  } sym_t;

  sym_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cap_xr[2], cap_xi[2], cap_raw[2];

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  function automatic int lvl(input logic s, input logic inner);
    int mag;
    mag = inner ? 256 : 768;
    return s ? -mag : mag;
  endfunction

  // Appends the expected symbol stream of one word to exp_q.
  function automatic void build_exp(input logic [127:0] w, input logic [1:0] m);
    int k;
    int ns;
    logic [127:0] sh;
    logic [3:0] nib;
    sym_t e;
    k  = (m == 2'd2) ? 4 : (m == 2'd1) ? 2 : 1;
    ns = 128 / k;
    for (int s = 0; s < ns; s++) begin
      sh  = w >> (s * k);
      nib = sh[3:0];
      if (k == 1) nib = nib & 4'b0001;
      if (k == 2) nib = nib & 4'b0011;
      if (k == 4) begin
        e.xr = lvl(nib[0], nib[2]);
        e.xi = lvl(nib[1], nib[3]);
      end else begin
        e.xr = nib[0] ? -256 : 256;
        e.xi = (k == 2) ? (nib[1] ? -256 : 256) : 0;
      end
      e.raw  = int'(nib);
      e.last = (s == ns - 1) ? 1 : 0;
      exp_q.push_back(e);
    end
  endfunction

  task automatic check_sym(input string tag, input int idx);
    string t;
    t = $sformatf("%s[%0d]", tag, idx);
    chk({t, "_valid"}, valid_o, 1);
    chk({t, "_xr"}, xr, exp_q[idx].xr);
    chk({t, "_xi"}, xi, exp_q[idx].xi);
    chk({t, "_raw"}, raw, exp_q[idx].raw);
    chk({t, "_last"}, last, exp_q[idx].last);
  endtask

  // Offers one word to an idle block and checks its whole symbol stream.
  task automatic run_word(input string tag, input logic [127:0] w, input logic [1:0] m);
    int ns;
    ns = (m == 2'd2) ? 32 : (m == 2'd1) ? 64 : 128;
    exp_q.delete();
    build_exp(w, m);
    ce = 1'b1;
    in_valid = 1'b1;
    in_data = w;
    mode = m;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    for (int n = 0; n < ns; n++) begin
      @(posedge CLK); #1;
      check_sym(tag, n);
      chk({tag, "_ready"}, in_ready, 1);
      if (n < 2) begin
        cap_xr[n] = int'(xr);
        cap_xi[n] = int'(xi);
        cap_raw[n] = int'(raw);
      end
    end
    @(posedge CLK); #1;
    chk({tag, "_valid_fall"}, valid_o, 0);
  endtask

  logic [127:0] words[3];
  logic [1:0]   modes[3];
  int           idx;
  int           s;
  logic         acc;
  logic         ce_now;

  initial begin
    RST = 1'b0;
    ce = 1'b0;
    mode = 2'd0;
    in_valid = 1'b0;
    in_data = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_xr", xr, 0);
    chk("rst_xi", xi, 0);
    chk("rst_raw", raw, 0);
    chk("rst_last", last, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;

    // BPSK word 0x5
    run_word("bpsk", 128'h5, 2'd0);
    chk("bpsk_s0_xr", cap_xr[0], -256);
    chk("bpsk_s0_xi", cap_xi[0], 0);
    chk("bpsk_s1_xr", cap_xr[1], 256);
    chk("bpsk_s0_raw", cap_raw[0], 1);

    // QPSK, low nibble 0110
    run_word("qpsk", 128'hA5C3_0F0F_1234_5678_9ABC_DEF0_1357_9B06, 2'd1);
    chk("qpsk_s0_xr", cap_xr[0], 256);
    chk("qpsk_s0_xi", cap_xi[0], -256);
    chk("qpsk_s1_xr", cap_xr[1], -256);
    chk("qpsk_s1_xi", cap_xi[1], 256);

    // Reserved mode behaves as BPSK
    run_word("rsvd", 128'h8000_0000_0000_0000_0000_0000_0000_0002, 2'd3);
    chk("rsvd_s1_xr", cap_xr[1], -256);
    chk("rsvd_s1_raw", cap_raw[1], 1);

    // ce toggled mid-word: held cycles repeat the previous symbol
    exp_q.delete();
    build_exp(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 2'd1);
    ce = 1'b1;
    in_valid = 1'b1;
    in_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    mode = 2'd1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    s = 0;
    for (int it = 0; it < 200 && s < 64; it++) begin
      ce_now = !(s >= 1 && s < 12 && (it % 3 == 2));
      ce = ce_now;
      @(posedge CLK); #1;
      if (ce_now) begin
        check_sym("ce_run", s);
        s++;
      end else begin
        check_sym("ce_hold", s - 1);
      end
    end
    ce = 1'b1;
    chk("ce_all_symbols", s, 64);
    repeat (2) @(posedge CLK);
    #1;

    // Three words back-to-back: BPSK, QPSK, 16QAM
    words[0] = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF1;
    words[1] = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    words[2] = 128'h7654_3210_FEDC_BA98_0123_4567_89AB_CDE4;
    modes[0] = 2'd0;
    modes[1] = 2'd1;
    modes[2] = 2'd2;
    exp_q.delete();
    for (int w = 0; w < 3; w++) build_exp(words[w], modes[w]);
    ce = 1'b1;
    in_valid = 1'b1;
    in_data = words[0];
    mode = modes[0];
    @(posedge CLK); #1;
    idx = 1;
    in_data = words[1];
    mode = modes[1];
    for (int n = 1; n <= 224; n++) begin
      acc = in_valid && in_ready;
      @(posedge CLK); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_data = words[idx];
          mode = modes[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      check_sym("b2b", n - 1);
      if (n == 1)   chk("b2b_ready_drop", in_ready, 0);
      if (n == 127) chk("b2b_ready_low", in_ready, 0);
      if (n == 128) chk("b2b_ready_rise", in_ready, 1);
      if (n == 129) chk("b2b_ready_drop2", in_ready, 0);
      if (n == 192) chk("b2b_ready_rise2", in_ready, 1);
    end
    @(posedge CLK); #1;
    chk("b2b_valid_fall", valid_o, 0);
    chk("b2b_words_taken", idx, 3);

    // Reset mid-16QAM word with a word pending
    ce = 1'b1;
    in_valid = 1'b1;
    in_data = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    mode = 2'd2;
    @(posedge CLK); #1;
    in_data = 128'h3;
    mode = 2'd0;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("rmid_pend_full", in_ready, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rmid_valid_before", valid_o, 1);
    RST = 1'b0;
    #1;
    chk("rmid_valid", valid_o, 0);
    chk("rmid_xr", xr, 0);
    chk("rmid_xi", xi, 0);
    chk("rmid_raw", raw, 0);
    chk("rmid_last", last, 0);
    chk("rmid_ready", in_ready, 1);
    #2;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rmid_no_resume", valid_o, 0);
    chk("rmid_ready_after", in_ready, 1);

    // 16QAM word after reset, nibbles 0001 then 1111
    run_word("qam", 128'h0123_4567_89AB_CDEF_0246_8ACE_1357_9BF1, 2'd2);
    chk("qam_s0_xr", cap_xr[0], -768);
    chk("qam_s0_xi", cap_xi[0], 768);
    chk("qam_s0_raw", cap_raw[0], 1);
    chk("qam_s1_xr", cap_xr[1], -256);
    chk("qam_s1_xi", cap_xi[1], -256);
    chk("qam_s1_raw", cap_raw[1], 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iqmap_multi.md
# iqmap_multi

Parametrised successor to the single-mode BPSK mapper. It accepts packed payload words over a ready/valid handshake and serialises them LSB-first into BPSK, QPSK or 16QAM symbols. Each symbol is emitted as a signed Gray-coded I/Q pair. The block sits between the payload reader and the IFFT carrier-loading stage of the one-seg transmit chain, and a one-word pending buffer keeps symbol output gap-free across word boundaries.

## Interface
- WORD_W, 128, payload word width; must be a multiple of 4.
- OUT_W, 11, signed I/Q output width.
- AMP, 256, unit amplitude; 3*AMP must be ≤ 2^(OUT_W-1)-1 (elaboration-time check).
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- ce  in  1  downstream advance enable; symbol outputs hold while low.
- mode  in  2  0=BPSK, 1=QPSK, 2=16QAM, 3=reserved (treated as BPSK); sampled with each accepted word.
- in_valid  in  1  word offered.
- in_data  in  WORD_W  payload word.
- in_ready  out  1  block can accept a word this cycle.
- xr  out  OUT_W  signed in-phase value.
- xi  out  OUT_W  signed quadrature value.
- valid_o  out  1  xr/xi/raw/last hold a valid symbol.
- raw  out  4  symbol bits, bit0 = first bit consumed; unused bits are 0.
- last  out  1  current symbol is the final symbol of its word.

## Operation
- Storage: active word + mode + bit index `cnt` (log2(WORD_W) bits); pending word + mode + pending-full flag.
- States:
  - IDLE: no active word.
  - RUN: active word being serialised.
- Transitions:
  - IDLE→RUN: a word is accepted.
  - RUN→IDLE: last symbol issued with ce high and pending empty.
  - At that same point with pending full, stay in RUN: pending moves to active and cnt clears.
- `in_ready` = !pending_full. An accepted word goes to active if IDLE, otherwise to pending.
- Bits per symbol k: 1, 2, 4 for BPSK, QPSK, 16QAM. Symbols per word: WORD_W/k, i.e. 128, 64, 32 at default.
- Each ce-high cycle in RUN: take bits [cnt+k-1:cnt], register the mapping, then cnt += k.
- Mapping (bit b0 first):
  - BPSK: xr = b0 ? −AMP : +AMP; xi = 0.
  - QPSK: xr from b0, xi from b1, same rule as BPSK.
  - 16QAM: xr from (b0,b2), xi from (b1,b3), Gray-coded 00→+3A, 01→+A, 11→−A, 10→−3A.
- Arithmetic: all values are computed at OUT_W signed; no saturation is needed because of the parameter check.
- Reserved mode: behaves exactly as BPSK, with raw[0] carrying the bit.
- Boundary cases:
  - A word accepted in the same cycle that the last symbol of the active word issues with pending empty goes straight to active. There is no bubble.
  - in_ready is high that cycle because pending is empty.
  - ce low: cnt, outputs and state freeze; words can still be accepted while pending is empty.
  - Reset mid-word: both words are discarded and nothing is resumed.

## Timing
- Reset values: in_ready=1, valid_o=0, xr=0, xi=0, raw=0, last=0, cnt=0, pending empty, state IDLE.
- Latency: word accepted at edge t → first symbol on outputs after edge t+1, provided ce is high in cycle t+1.
- With ce held high, symbols are back-to-back: WORD_W/k consecutive valid cycles per word. Consecutive words are seamless if the next word arrives before the last symbol of the current one.
- valid_o falls on the edge after the last symbol when no word is queued. It stays high and unchanged while ce is low.
- last is registered together with its symbol.

## Structure
- Package iqmap_pkg holds:
  - the mode enum (MODE_BPSK, MODE_QPSK, MODE_16QAM, MODE_RSVD);
  - the bits-per-mode function;
  - the Gray level codes.
- Sub-module iqmap_symbol_lut: combinational mapping of (mode, 4 bits) → (xr, xi), parameterised by OUT_W and AMP. The control/buffering FSM lives in iqmap_multi.

## Test plan
- Reset, then one BPSK word 0x…0005 with ce=1 → xr = −256, +256, −256, +256, … (bit0=1 → −256); xi=0; 128 valid cycles; last on cycle 128; in_ready stays high.
- QPSK word, low nibble 0b0110 → symbol 0: (+256, −256), symbol 1: (−256, +256); 64 symbols; last on the 64th.
- 16QAM word, low nibble 0b0001 (b0=1,b1=0,b2=0,b3=0) → xr=−768, xi=+768; second nibble 0b1111 → xr=−256, xi=−256.
- Three words offered back-to-back (BPSK, QPSK, 16QAM) → in_ready drops after the second, rises at the first word's last symbol; valid_o stays continuously high for 128+64+32 cycles with no gaps.
- ce toggled 1-0-1 mid-word → outputs and cnt hold during low cycles; symbol sequence is identical to the ce=1 run.
- RST asserted mid-16QAM word with a word pending → all outputs return to reset values immediately; a new word after release starts at bit 0.
